rdm_byte_buf: RTL and testbench

- Random-byte supplier directly upstream of the Bernoulli compare stage in the SamplerZ datapath.
- Accepts 64-bit random words from the PRNG over a valid/ready handshake and buffers them in a small word FIFO.
- Serves one registered byte per request, so the compare stage always finds a fresh rdm8 on the cycle after it raises rdm_req.
- Reports buffer level and underruns so the sampler controller can stall before starting a comparison.

---
 rtl/sampler_pkg.sv | 19 +
 rtl/rdm_word_fifo.sv | 76 +++++++
 rtl/rdm_byte_buf.sv | 122 ++++++++++++
 tb/tb_rdm_byte_buf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared SamplerZ datapath types and constants for the random-byte path.
package sampler_pkg;

    localparam int unsigned RDM_WORD_W     = 64;
    localparam int unsigned RDM_BYTE_W     = 8;
    localparam int unsigned BYTES_PER_WORD = 8;

    typedef logic [RDM_WORD_W-1:0] rdm_word_t;
    typedef logic [RDM_BYTE_W-1:0] rdm_byte_t;
    typedef logic [2:0]            byte_idx_t;

    // Byte idx of a word, LSB-first.
    function automatic rdm_byte_t select_byte(rdm_word_t word, byte_idx_t idx);
        rdm_word_t shifted;
        shifted = word >> {idx, 3'b000};
        return shifted[RDM_BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/rdm_word_fifo.sv
// Synchronous DEPTH x 64-bit word FIFO with push/pop and a single-cycle flush.
module rdm_word_fifo
    import sampler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  rdm_word_t push_data_i,
    input  logic      pop_i,
    output rdm_word_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rdm_word_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o && !flush_i;
    assign pop_en  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_en && !pop_en) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_en && !push_en) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rdm_byte_buf.sv
// Random-byte supplier for the Bernoulli compare stage: buffers PRNG words, serves one byte/req.
// Optional counters enabled by RDM_BYTE_BUF_STATS_EN (bytes_served, underrun_cnt).
module rdm_byte_buf
    import sampler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH * 8 + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  rdm_word_t        prng_data,
    input  logic             prng_valid,
    output logic             prng_ready,
    input  logic             flush,
    input  logic             rdm_req,
    output rdm_byte_t        rdm8,
    output logic             rdm_ok,
    output logic [LVL_W-1:0] avail_bytes,
    output logic             underrun
`ifdef RDM_BYTE_BUF_STATS_EN
    ,
    output logic [31:0]      bytes_served,
    output logic [15:0]      underrun_cnt
`endif
);

    rdm_word_t        head_word;
    logic             fifo_full, fifo_empty;
    logic             push_acc, req_ok, req_empty, pop;

    byte_idx_t        byte_idx_q, byte_idx_d;
    rdm_byte_t        rdm8_q, rdm8_d;
    logic             underrun_q, underrun_d;
    logic [LVL_W-1:0] avail_q, avail_d;

    assign prng_ready = !rst && !fifo_full;
    assign push_acc   = prng_valid && prng_ready && !flush;
    assign req_ok     = rdm_req && !fifo_empty && !flush;
    assign req_empty  = rdm_req && fifo_empty && !flush;
    assign pop        = req_ok && (byte_idx_q == 3'd7);

    rdm_word_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .push_i     (push_acc),
        .push_data_i(prng_data),
        .pop_i      (pop),
        .head_o     (head_word),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        byte_idx_d = byte_idx_q;
        rdm8_d     = rdm8_q;
        underrun_d = underrun_q;
        avail_d    = avail_q;
        if (flush) begin
            byte_idx_d = '0;
            underrun_d = 1'b0;
            avail_d    = '0;
        end else begin
            if (req_ok) begin
                rdm8_d     = select_byte(head_word, byte_idx_q);
                byte_idx_d = byte_idx_q + 3'd1;
            end
            if (req_empty) begin
                underrun_d = 1'b1;
            end
            // A pop at byte 7 nets to -1 byte, same as any other served byte.
            avail_d = avail_q
                    + (push_acc ? LVL_W'(BYTES_PER_WORD) : '0)
                    - (req_ok ? LVL_W'(1) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
            rdm8_q     <= '0;
            underrun_q <= 1'b0;
            avail_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            rdm8_q     <= rdm8_d;
            underrun_q <= underrun_d;
            avail_q    <= avail_d;
        end
    end

    assign rdm8        = rdm8_q;
    assign rdm_ok      = !fifo_empty;
    assign avail_bytes = avail_q;
    assign underrun    = underrun_q;

`ifdef RDM_BYTE_BUF_STATS_EN
    logic [31:0] bytes_served_q;
    logic [15:0] underrun_cnt_q;

    // Saturating; only rst clears them so they survive reseeds.
    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_served_q <= '0;
            underrun_cnt_q <= '0;
        end else begin
            if (req_ok && (bytes_served_q != '1)) begin
                bytes_served_q <= bytes_served_q + 32'd1;
            end
            if (req_empty && (underrun_cnt_q != '1)) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
        end
    end

    assign bytes_served = bytes_served_q;
    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_rdm_byte_buf.sv
// Self-checking bench for rdm_byte_buf: byte-queue reference model plus directed literal checks.
module tb_rdm_byte_buf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH * 8 + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      prng_data;
    logic             prng_valid;
    logic             prng_ready;
    logic             flush;
    logic             rdm_req;
    logic [7:0]       rdm8;
    logic             rdm_ok;
    logic [LVL_W-1:0] avail_bytes;
    logic             underrun;

    always #5 clk = ~clk;

    rdm_byte_buf #(
        .DEPTH(DEPTH),
        .LVL_W(LVL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prng_data  (prng_data),
        .prng_valid (prng_valid),
        .prng_ready (prng_ready),
        .flush      (flush),
        .rdm_req    (rdm_req),
        .rdm8       (rdm8),
        .rdm_ok     (rdm_ok),
        .avail_bytes(avail_bytes),
        .underrun   (underrun)
    );

    int checks   = 0;
    int failures = 0;

    // Model: the unread bytes in serving order, the last served byte, the sticky flag.
    byte unsigned mq[$];
    logic [7:0]   m_rdm8;
    logic         m_under;
    bit           m_valid = 1'b0;

    function automatic int m_words();
        return (mq.size() + 7) / 8;
    endfunction

    function automatic bit m_ready();
        return (rst == 1'b0) && (m_words() < DEPTH);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (!m_valid) return;
        check("rdm8", 64'(rdm8), 64'(m_rdm8));
        check("rdm_ok", 64'(rdm_ok), 64'(mq.size() != 0));
        check("avail_bytes", 64'(avail_bytes), 64'(mq.size()));
        check("prng_ready", 64'(prng_ready), 64'(m_ready()));
        check("underrun", 64'(underrun), 64'(m_under));
    endtask

    // Compare at negedge, advance the model at the edge; returns 1ns after it.
    task automatic tick();
        bit push;
        @(negedge clk);
        compare();
        push = prng_valid && m_ready();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rdm8  = 8'h00;
            m_under = 1'b0;
            m_valid = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_under = 1'b0;
        end else begin
            if (rdm_req) begin
                if (mq.size() > 0) m_rdm8 = mq.pop_front();
                else m_under = 1'b1;
            end
            if (push) begin
                for (int b = 0; b < 8; b++) mq.push_back(prng_data[8*b +: 8]);
            end
        end
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    logic [63:0] wl [5];
    int          k;
    logic        was_ready;

    initial begin
        rst        = 1'b1;
        prng_data  = '0;
        prng_valid = 1'b0;
        flush      = 1'b0;
        rdm_req    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_avail", 64'(avail_bytes), 64'd0);
        check("rst_rdm8", 64'(rdm8), 64'h00);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_rdm_ok", 64'(rdm_ok), 64'd0);
        check("rel_ready", 64'(prng_ready), 64'd1);

        // Empty request, then push and serve LSB-first.
        rdm_req = 1'b1;
        tick();
        rdm_req = 1'b0;
        check("empty_req_underrun", 64'(underrun), 64'd1);
        check("empty_req_rdm8", 64'(rdm8), 64'h00);
        prng_valid = 1'b1;
        prng_data  = 64'h0706_0504_0302_0100;
        tick();
        prng_valid = 1'b0;
        check("push_avail", 64'(avail_bytes), 64'd8);
        check("push_rdm_ok", 64'(rdm_ok), 64'd1);
        for (int i = 0; i < 8; i++) begin
            rdm_req = 1'b1;
            tick();
            check("seq_byte", 64'(rdm8), 64'(i));
            check("seq_avail", 64'(avail_bytes), 64'(7 - i));
        end
        rdm_req = 1'b0;
        check("seq_rdm_ok_drop", 64'(rdm_ok), 64'd0);
        check("seq_underrun_sticky", 64'(underrun), 64'd1);

        // Fill to DEPTH, hold the fifth word, pop one word to release it.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_clears_underrun", 64'(underrun), 64'd0);
        for (int i = 0; i < 5; i++) wl[i] = rand64();
        k = 0;
        prng_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            prng_data = wl[k];
            was_ready = prng_ready;
            tick();
            if (was_ready) k++;
        end
        check("full_accepted", 64'(k), 64'd4);
        check("full_ready", 64'(prng_ready), 64'd0);
        prng_data = wl[4];
        rdm_req   = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        rdm_req = 1'b0;
        check("ready_after_pop", 64'(prng_ready), 64'd1);
        tick();
        prng_valid = 1'b0;
        check("fifth_accepted_avail", 64'(avail_bytes), 64'd32);
        check("fifth_full_ready", 64'(prng_ready), 64'd0);
        rdm_req = 1'b1;
        for (int c = 0; c < 32; c++) tick();
        rdm_req = 1'b0;
        check("fifth_last_byte", 64'(rdm8), 64'(wl[4][63:56]));

        // Flush colliding with push and request.
        rdm_req = 1'b1;
        tick();
        rdm_req    = 1'b0;
        prng_valid = 1'b1;
        prng_data  = {8{8'h11}};
        tick();
        prng_valid = 1'b0;
        rdm_req    = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        flush      = 1'b1;
        prng_valid = 1'b1;
        prng_data  = {8{8'h22}};
        tick();
        flush      = 1'b0;
        prng_valid = 1'b0;
        rdm_req    = 1'b0;
        check("flush_avail", 64'(avail_bytes), 64'd0);
        check("flush_underrun", 64'(underrun), 64'd0);
        check("flush_rdm8_hold", 64'(rdm8), 64'h11);
        check("flush_rdm_ok", 64'(rdm_ok), 64'd0);

        // Sustained rate: one word per 8 cycles, one byte per cycle.
        prng_valid = 1'b1;
        prng_data  = rand64();
        tick();
        for (int c = 0; c < 64; c++) begin
            rdm_req    = 1'b1;
            prng_valid = (c % 8 == 0);
            prng_data  = rand64();
            tick();
        end
        rdm_req    = 1'b0;
        prng_valid = 1'b0;
        check("rate_no_underrun", 64'(underrun), 64'd0);
        check("rate_avail", 64'(avail_bytes), 64'd8);

        // Reset with two words buffered and byte_idx at 5.
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        prng_valid = 1'b1;
        prng_data  = rand64();
        tick();
        prng_data = rand64();
        tick();
        prng_valid = 1'b0;
        rdm_req    = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        rdm_req = 1'b0;
        check("pre_rst_avail", 64'(avail_bytes), 64'd11);
        rst = 1'b1;
        tick();
        check("mid_rst_avail", 64'(avail_bytes), 64'd0);
        check("mid_rst_rdm8", 64'(rdm8), 64'h00);
        check("mid_rst_ready", 64'(prng_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(prng_ready), 64'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(199) == 0);
            flush      = ($urandom_range(49) == 0);
            prng_valid = ($urandom_range(2) != 0);
            rdm_req    = ($urandom_range(3) != 0);
            prng_data  = rand64();
            tick();
        end
        rst        = 1'b0;
        flush      = 1'b0;
        prng_valid = 1'b0;
        rdm_req    = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
